// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first magnitude comparator: one shared 1-bit gt/eq/lt cell scans two operands.
// Optional build macro EARLY_EXIT_EN: stop scanning at the first differing bit.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] IdxMsb = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] IdxOne = CntW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  // Shared comparator cell on the currently selected bit pair.
  logic a_bit, b_bit;
  logic cell_gt, cell_eq, cell_lt;
  logic last_bit;

  assign a_bit    = a_q[idx_q];
  assign b_bit    = b_q[idx_q];
  assign cell_gt  = a_bit & ~b_bit;
  assign cell_eq  = ~(a_bit ^ b_bit);
  assign cell_lt  = ~a_bit & b_bit;
  assign last_bit = (idx_q == '0);

`ifndef EARLY_EXIT_EN
  // Once a differing bit has been seen the verdict is frozen for the rest of the scan.
  logic decided;
  assign decided = gt_q | lt_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          idx_d   = IdxMsb;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
`ifdef EARLY_EXIT_EN
        if (!cell_eq) begin
          gt_d    = cell_gt;
          lt_d    = cell_lt;
          state_d = StDone;
        end else if (last_bit) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxOne;
        end
`else
        if (!decided && !cell_eq) begin
          gt_d = cell_gt;
          lt_d = cell_lt;
        end
        if (last_bit) begin
          eq_d    = !decided && cell_eq;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxOne;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign gt_o   = gt_q;
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;

endmodule
